// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, state numbers,
// ALU/mux select codes and the bundle of control strobes.
package multicycle_control_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    // ALUop classes are also decoded by ALUControl, keep the two in step.
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side.
interface multicycle_control_if;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic [1:0] PCSource;
    logic [3:0] State;
    logic       IllegalOp;

    modport master (
        input  Op, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, State, IllegalOp
    );

    modport slave (
        output Op, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, State, IllegalOp
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS subset with a memory-ready handshake
// and a sticky illegal-opcode flag.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input logic              Clk,
    input logic              Reset,
    multicycle_control_if.master bus
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl, ctrl_o;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        ctrl      = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_write  = bus.MemReady;
                ctrl.ir_write  = bus.MemReady;
                state_d        = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
                case (bus.Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                state_d       = bus.MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                state_d        = bus.MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNC;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset kills every strobe combinationally, even in the middle of an access.
    assign ctrl_o = Reset ? '0 : ctrl;

    assign bus.PCWrite     = ctrl_o.pc_write;
    assign bus.PCWriteCond = ctrl_o.pc_write_cond;
    assign bus.IorD        = ctrl_o.iord;
    assign bus.MemRead     = ctrl_o.mem_read;
    assign bus.MemWrite    = ctrl_o.mem_write;
    assign bus.IRWrite     = ctrl_o.ir_write;
    assign bus.MemtoReg    = ctrl_o.mem_to_reg;
    assign bus.RegDst      = ctrl_o.reg_dst;
    assign bus.RegWrite    = ctrl_o.reg_write;
    assign bus.ALUSrcA     = ctrl_o.alu_src_a;
    assign bus.ALUSrcB     = ctrl_o.alu_src_b;
    assign bus.ALUop       = ctrl_o.alu_op;
    assign bus.PCSource    = ctrl_o.pc_source;
    assign bus.State       = state_q;
    assign bus.IllegalOp   = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level model builds the expected
// per-cycle state trace; a per-state output table supplies expected strobes.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    multicycle_control_if bus();
    multicycle_control dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        int         fw;
        int         mw;
    } vec_t;

    outs_t exp_tab [16];
    vec_t  dir [8];
    int    q_st [$];
    bit    q_mr [$];
    int    checks = 0;
    int    errors = 0;
    logic  ill_exp = 1'b0;

    function automatic outs_t actual();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUop, bus.PCSource};
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int st, input bit mr);
        q_st.push_back(st);
        q_mr.push_back(mr);
    endtask

    // Path of states an instruction walks, with handshake waits inserted.
    task automatic build(input logic [5:0] op, input int fw, input int mw);
        q_st.delete();
        q_mr.delete();
        repeat (fw) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'($urandom));
        case (op)
            6'b100011: begin
                push(2, 1'($urandom));
                repeat (mw) push(3, 1'b0);
                push(3, 1'b1);
                push(4, 1'($urandom));
            end
            6'b101011: begin
                push(2, 1'($urandom));
                repeat (mw) push(5, 1'b0);
                push(5, 1'b1);
            end
            6'b000000: begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
            6'b001000: begin push(9, 1'($urandom)); push(10, 1'($urandom)); end
            6'b000100: push(8, 1'($urandom));
            6'b000010: push(11, 1'($urandom));
            default: ;
        endcase
    endtask

    function automatic int base_lat(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic run(input logic [5:0] op, input int fw, input int mw);
        outs_t e;
        build(op, fw, mw);
        chk("latency", q_st.size(), base_lat(op) + fw + ((op == 6'b100011 || op == 6'b101011) ? mw : 0));
        for (int i = 0; i < q_st.size(); i++) begin
            @(negedge Clk);
            bus.Op = op;
            bus.MemReady = q_mr[i];
            #1;
            chk($sformatf("state[%0d] op=%b", i, op), bus.State, q_st[i]);
            e = exp_tab[q_st[i]];
            if (q_st[i] == 0) begin
                e.pcw = q_mr[i];
                e.irw = q_mr[i];
            end
            chk($sformatf("outs st=%0d", q_st[i]), actual(), e);
            chk("illegal_op", bus.IllegalOp, ill_exp);
            if (q_st[i] == 1 && !legal(op)) ill_exp = 1'b1;
        end
    endtask

    initial begin
        logic [5:0] rop;
        int pick;
        logic [5:0] ops [7];

        foreach (exp_tab[k]) exp_tab[k] = '0;
        exp_tab[0]  = '{pcw:0, pcwc:0, iord:0, mrd:1, mwr:0, irw:0, m2r:0, rdst:0, rw:0, srca:0, srcb:2'b01, aluop:2'b00, pcsrc:2'b00};
        exp_tab[1]  = '{pcw:0, pcwc:0, iord:0, mrd:0, mwr:0, irw:0, m2r:0, rdst:0, rw:0, srca:0, srcb:2'b11, aluop:2'b00, pcsrc:2'b00};
        exp_tab[2]  = '{pcw:0, pcwc:0, iord:0, mrd:0, mwr:0, irw:0, m2r:0, rdst:0, rw:0, srca:1, srcb:2'b10, aluop:2'b00, pcsrc:2'b00};
        exp_tab[3]  = '{pcw:0, pcwc:0, iord:1, mrd:1, mwr:0, irw:0, m2r:0, rdst:0, rw:0, srca:0, srcb:2'b00, aluop:2'b00, pcsrc:2'b00};
        exp_tab[4]  = '{pcw:0, pcwc:0, iord:0, mrd:0, mwr:0, irw:0, m2r:1, rdst:0, rw:1, srca:0, srcb:2'b00, aluop:2'b00, pcsrc:2'b00};
        exp_tab[5]  = '{pcw:0, pcwc:0, iord:1, mrd:0, mwr:1, irw:0, m2r:0, rdst:0, rw:0, srca:0, srcb:2'b00, aluop:2'b00, pcsrc:2'b00};
        exp_tab[6]  = '{pcw:0, pcwc:0, iord:0, mrd:0, mwr:0, irw:0, m2r:0, rdst:0, rw:0, srca:1, srcb:2'b00, aluop:2'b10, pcsrc:2'b00};
        exp_tab[7]  = '{pcw:0, pcwc:0, iord:0, mrd:0, mwr:0, irw:0, m2r:0, rdst:1, rw:1, srca:0, srcb:2'b00, aluop:2'b00, pcsrc:2'b00};
        exp_tab[8]  = '{pcw:0, pcwc:1, iord:0, mrd:0, mwr:0, irw:0, m2r:0, rdst:0, rw:0, srca:1, srcb:2'b00, aluop:2'b01, pcsrc:2'b01};
        exp_tab[9]  = '{pcw:0, pcwc:0, iord:0, mrd:0, mwr:0, irw:0, m2r:0, rdst:0, rw:0, srca:1, srcb:2'b10, aluop:2'b00, pcsrc:2'b00};
        exp_tab[10] = '{pcw:0, pcwc:0, iord:0, mrd:0, mwr:0, irw:0, m2r:0, rdst:0, rw:1, srca:0, srcb:2'b00, aluop:2'b00, pcsrc:2'b00};
        exp_tab[11] = '{pcw:1, pcwc:0, iord:0, mrd:0, mwr:0, irw:0, m2r:0, rdst:0, rw:0, srca:0, srcb:2'b00, aluop:2'b00, pcsrc:2'b10};

        dir[0] = '{op: 6'b100011, fw: 0, mw: 0};
        dir[1] = '{op: 6'b101011, fw: 0, mw: 3};
        dir[2] = '{op: 6'b000000, fw: 2, mw: 0};
        dir[3] = '{op: 6'b000100, fw: 0, mw: 0};
        dir[4] = '{op: 6'b000010, fw: 0, mw: 0};
        dir[5] = '{op: 6'b001000, fw: 1, mw: 0};
        dir[6] = '{op: 6'b111111, fw: 0, mw: 0};
        dir[7] = '{op: 6'b000000, fw: 0, mw: 0};

        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b000000;

        // Reset state with MemReady high: strobes must stay forced low.
        bus.Op = 6'b100011;
        bus.MemReady = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        chk("reset state", bus.State, 4'd0);
        chk("reset outs", actual(), '0);
        chk("reset illegal", bus.IllegalOp, 1'b0);
        @(negedge Clk);
        bus.MemReady = 1'b0;
        Reset = 1'b0;

        foreach (dir[k]) run(dir[k].op, dir[k].fw, dir[k].mw);

        // Reset while MEMRD is stalled: outputs drop at once, sticky flag clears.
        @(negedge Clk); bus.Op = 6'b100011; bus.MemReady = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk); bus.MemReady = 1'b0;
        #1;
        chk("memrd before reset", bus.State, 4'd3);
        chk("illegal before reset", bus.IllegalOp, 1'b1);
        Reset = 1'b1;
        #1;
        chk("mid-access reset state", bus.State, 4'd0);
        chk("mid-access reset outs", actual(), '0);
        chk("mid-access reset illegal", bus.IllegalOp, 1'b0);
        ill_exp = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        run(6'b000000, 0, 0);

        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 7);
            if (pick == 7) begin
                do rop = 6'($urandom); while (legal(rop));
            end else begin
                rop = ops[pick];
            end
            run(rop, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Clk  in  1  sole clock; all state changes on rising edge.
REQ-002 Reset  in  1  asynchronous, active-high reset.
REQ-003 Op  in  6  instruction opcode field from IR; sampled in DECODE and MEMADR only.
REQ-004 MemReady  in  1  memory handshake; high = current access completes this cycle.
REQ-005 PCWrite  out  1  unconditional PC load.
REQ-006 PCWriteCond  out  1  PC load qualified by ALU Zero (beq).
REQ-007 IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 MemRead  out  1  memory read request.
REQ-009 MemWrite  out  1  memory write request.
REQ-010 IRWrite  out  1  instruction register load.
REQ-011 MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
REQ-012 RegDst  out  1  destination register select: 0 = rt, 1 = rd.
REQ-013 RegWrite  out  1  register file write enable.
REQ-014 ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
REQ-015 ALUSrcB  out  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-016 ALUop  out  2  ALU control class: 00 = add, 01 = subtract, 10 = decode by FuncCode.
REQ-017 PCSource  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-018 State  out  4  current state encoding, for debug and verification.
REQ-019 IllegalOp  out  1  sticky flag: an unsupported opcode was decoded.

Function
REQ-020 Moore FSM; every output SHALL be 0 in every state unless listed below.
REQ-021 Opcodes SHALL be: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
REQ-022 FETCH(0)
- Outputs: MemRead=1, ALUSrcB=01, ALUop=00.
- PCWrite=IRWrite=MemReady.
- Transitions: stay while MemReady=0; else go to DECODE.
REQ-023 DECODE(1)
- Outputs: ALUSrcB=11, ALUop=00.
- Transitions: lw/sw -> MEMADR, R -> EXECUTE, beq -> BRANCH, addi -> ADDIEX, j -> JUMP.
- Any other opcode -> FETCH, and IllegalOp set on that edge.
REQ-024 MEMADR(2)
- Outputs: ALUSrcA=1, ALUSrcB=10, ALUop=00.
- Transitions: lw -> MEMRD; else -> MEMWR.
REQ-025 MEMRD(3)
- Outputs: MemRead=1, IorD=1.
- Transitions: stay while MemReady=0; else -> MEMWB.
REQ-026 MEMWB(4)
- Outputs: RegWrite=1, MemtoReg=1, RegDst=0.
- Transitions: -> FETCH.
REQ-027 MEMWR(5)
- Outputs: MemWrite=1, IorD=1.
- Transitions: stay while MemReady=0; else -> FETCH.
REQ-028 EXECUTE(6)
- Outputs: ALUSrcA=1, ALUSrcB=00, ALUop=10.
- Transitions: -> ALUWB.
REQ-029 ALUWB(7)
- Outputs: RegWrite=1, RegDst=1.
- Transitions: -> FETCH.
REQ-030 BRANCH(8)
- Outputs: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01.
- Transitions: -> FETCH.
REQ-031 ADDIEX(9)
- Outputs: ALUSrcA=1, ALUSrcB=10, ALUop=00.
- Transitions: -> ADDIWB.
REQ-032 ADDIWB(10)
- Outputs: RegWrite=1, RegDst=0.
- Transitions: -> FETCH.
REQ-033 JUMP(11)
- Outputs: PCWrite=1, PCSource=10.
- Transitions: -> FETCH.
REQ-034 Unused encodings 12-15 SHALL transition to FETCH on the next edge with all outputs 0.
REQ-035 Wait states SHALL hold all outputs constant, except PCWrite/IRWrite in FETCH, which follow MemReady.
REQ-036 Instruction latencies, zero-wait, in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2; each wait cycle adds 1.

Reset
REQ-037 While Reset=1: State=FETCH, IllegalOp=0, and all other outputs forced to 0 combinationally, including mid-access.
REQ-038 The first FETCH access SHALL begin on the first rising edge after Reset deasserts; IllegalOp clears only on Reset.

Structure
REQ-039 A shared definitions package SHALL hold:
- opcode constants,
- 4-bit state encodings,
- ALUop encodings, shared with ALUControl,
- ALUSrcB and PCSource encodings.
REQ-040 Single module with no sub-module: state register, next-state logic and output decode.

Verification
REQ-041 Reset, then lw with MemReady=1 always -> State 0,1,2,3,4,0; RegWrite=MemtoReg=1 only in state 4.
REQ-042 sw with MemReady low for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
REQ-043 FETCH with MemReady=0 for 2 cycles -> PCWrite=IRWrite=0 for 2 cycles, then exactly one cycle of 1.
REQ-044 beq sequence -> BRANCH shows ALUop=01, PCWriteCond=1, PCSource=01; j -> JUMP shows PCWrite=1, PCSource=10.
REQ-045 Op=111111 in DECODE -> FETCH next with IllegalOp=1 held; a following R-type still gives State 0,1,6,7.
REQ-046 Reset asserted in MEMRD with MemReady=0 -> all outputs 0 immediately; State=0 after release.
